// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, 32-step restoring divider,
// data-SRAM request issue and the EX forwarding bundle.
module ex_stage #(
  parameter int ID_TO_EX_WIDTH  = 152,
  parameter int EX_TO_MEM_WIDTH = 71
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       ex_allowin,
  input  logic                       id_to_ex_valid,
  input  logic [ID_TO_EX_WIDTH-1:0]  id_to_ex_wire,
  input  logic                       mem_allowin,
  output logic                       ex_to_mem_valid,
  output logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_wire,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic [38:0]                ex_rf_zip,
  output logic                       div_busy
);

  typedef struct packed {
    logic [15:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd;
    logic        mem_we;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } id_ex_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } div_st_t;

  id_ex_t      r_id;
  logic        r_ex_valid;
  div_st_t     r_state;
  div_st_t     w_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic        r_qneg;
  logic        r_rneg;

  logic        w_is_div;
  logic        w_sgn;
  logic        w_start;
  logic        w_ready_go;
  logic [4:0]  w_sa;
  logic [31:0] w_add;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_sh;
  logic [33:0] w_diff;
  logic        w_neg;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_res;

  assign w_is_div = |r_id.alu_op[15:12];
  assign w_sgn    = r_id.alu_op[12] | r_id.alu_op[13];
  assign w_start  = (r_state == S_IDLE) & r_ex_valid & w_is_div;

  assign w_ready_go      = ~w_is_div | (r_state == S_DONE);
  assign ex_allowin      = ~r_ex_valid | (w_ready_go & mem_allowin);
  assign ex_to_mem_valid = r_ex_valid & w_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ex_valid <= 1'b0;
    end else if (ex_allowin) begin
      r_ex_valid <= id_to_ex_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (id_to_ex_valid & ex_allowin) begin
      r_id <= id_to_ex_wire;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_nxt;
      if (w_start) begin
        r_cnt <= 5'd0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

  // DONE holds its result until MEM takes it; no restart from DONE.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_nxt = S_BUSY;
      S_BUSY: if (r_cnt == 5'd31) w_nxt = S_DONE;
      S_DONE: if (mem_allowin) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  assign div_busy = (r_state == S_BUSY);

  assign w_abs1 = (w_sgn & r_id.src1[31]) ? -r_id.src1 : r_id.src1;
  assign w_abs2 = (w_sgn & r_id.src2[31]) ? -r_id.src2 : r_id.src2;

  // 34-bit difference keeps the sign correct for a zero divisor.
  assign w_sh   = {r_rem, r_quo[31]};
  assign w_diff = {1'b0, w_sh} - {2'b00, r_dvs};
  assign w_neg  = w_diff[33];

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_quo  <= w_abs1;
      r_rem  <= 32'd0;
      r_dvs  <= w_abs2;
      r_qneg <= w_sgn & (r_id.src1[31] ^ r_id.src2[31]);
      r_rneg <= w_sgn & r_id.src1[31];
    end else if (r_state == S_BUSY) begin
      r_rem <= w_neg ? w_sh[31:0] : w_diff[31:0];
      r_quo <= {r_quo[30:0], ~w_neg};
    end
  end

  assign w_q = r_qneg ? -r_quo : r_quo;
  assign w_r = r_rneg ? -r_rem : r_rem;

  assign w_sa  = r_id.src2[4:0];
  assign w_add = r_id.src1 + r_id.src2;

  always_comb begin
    w_res = 32'd0;
    unique case (1'b1)
      r_id.alu_op[0]:  w_res = w_add;
      r_id.alu_op[1]:  w_res = r_id.src1 - r_id.src2;
      r_id.alu_op[2]:  w_res = {31'd0, $signed(r_id.src1) < $signed(r_id.src2)};
      r_id.alu_op[3]:  w_res = {31'd0, r_id.src1 < r_id.src2};
      r_id.alu_op[4]:  w_res = r_id.src1 & r_id.src2;
      r_id.alu_op[5]:  w_res = ~(r_id.src1 | r_id.src2);
      r_id.alu_op[6]:  w_res = r_id.src1 | r_id.src2;
      r_id.alu_op[7]:  w_res = r_id.src1 ^ r_id.src2;
      r_id.alu_op[8]:  w_res = r_id.src1 << w_sa;
      r_id.alu_op[9]:  w_res = r_id.src1 >> w_sa;
      r_id.alu_op[10]: w_res = $signed(r_id.src1) >>> w_sa;
      r_id.alu_op[11]: w_res = r_id.src2;
      r_id.alu_op[12]: w_res = w_q;
      r_id.alu_op[13]: w_res = w_r;
      r_id.alu_op[14]: w_res = w_q;
      r_id.alu_op[15]: w_res = w_r;
      default:         w_res = 32'd0;
    endcase
  end

  assign ex_to_mem_wire = {r_id.rf_we, r_id.rf_waddr, r_id.pc,
                           w_res, r_id.res_from_mem};

  assign data_sram_en    = r_ex_valid & w_ready_go & mem_allowin
                         & (r_id.mem_we | r_id.res_from_mem);
  assign data_sram_we    = {4{r_id.mem_we & r_ex_valid}};
  assign data_sram_addr  = w_add;
  assign data_sram_wdata = r_id.rkd;

  assign ex_rf_zip = {r_ex_valid & r_id.res_from_mem,
                      r_ex_valid & r_id.rf_we,
                      r_id.rf_waddr, w_res};

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: ALU/divider vector table through
// a scoreboard, plus directed handshake, stall and reset sequences.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ex_allowin;
  logic         id_to_ex_valid;
  logic [151:0] id_to_ex_wire;
  logic         mem_allowin;
  logic         ex_to_mem_valid;
  logic [70:0]  ex_to_mem_wire;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [38:0]  ex_rf_zip;
  logic         div_busy;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ex_allowin      (ex_allowin),
    .id_to_ex_valid  (id_to_ex_valid),
    .id_to_ex_wire   (id_to_ex_wire),
    .mem_allowin     (mem_allowin),
    .ex_to_mem_valid (ex_to_mem_valid),
    .ex_to_mem_wire  (ex_to_mem_wire),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ex_rf_zip       (ex_rf_zip),
    .div_busy        (div_busy)
  );

  typedef struct {
    logic [15:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam logic [15:0] ADD  = 16'h0001;
  localparam logic [15:0] SUB  = 16'h0002;
  localparam logic [15:0] SLT  = 16'h0004;
  localparam logic [15:0] SLTU = 16'h0008;
  localparam logic [15:0] AND  = 16'h0010;
  localparam logic [15:0] NOR  = 16'h0020;
  localparam logic [15:0] OR   = 16'h0040;
  localparam logic [15:0] XOR  = 16'h0080;
  localparam logic [15:0] SLL  = 16'h0100;
  localparam logic [15:0] SRL  = 16'h0200;
  localparam logic [15:0] SRA  = 16'h0400;
  localparam logic [15:0] LUI  = 16'h0800;
  localparam logic [15:0] DIV  = 16'h1000;
  localparam logic [15:0] MOD  = 16'h2000;
  localparam logic [15:0] DIVU = 16'h4000;
  localparam logic [15:0] MODU = 16'h8000;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          sb_on = 1'b0;
  logic [70:0] sbq[$];
  vec_t        tv[$];

  task automatic chk(input string nm, input logic [70:0] act,
                     input logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [151:0] mk(
    input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] rkd, input logic we, input logic rfm,
    input logic rfwe, input logic [4:0] wa, input logic [31:0] pc);
    return {op, a, b, rkd, we, rfm, rfwe, wa, pc};
  endfunction

  function automatic vec_t v(input logic [15:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] e);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.exp = e;
    return t;
  endfunction

  // Present w until EX accepts it; returns 1 ns after the accepting edge.
  task automatic send(input logic [151:0] w, input logic [70:0] exp,
                      input bit push);
    bit ok;
    ok = 1'b0;
    id_to_ex_wire  = w;
    id_to_ex_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ex_allowin) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 71'd0, 71'd1);
    if (push) sbq.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_on && resetn && ex_to_mem_valid && mem_allowin) begin
      if (sbq.size() == 0) chk("sb_extra", ex_to_mem_wire, 71'd0);
      else chk("sb", ex_to_mem_wire, sbq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    int          first;
    int          busy;
    int          alb;
    int          ens;
    bit          seen;
    logic [31:0] pc;
    logic [4:0]  wa;

    resetn         = 1'b0;
    id_to_ex_valid = 1'b0;
    id_to_ex_wire  = '0;
    mem_allowin    = 1'b1;
    #3;
    chk("rst_valid", ex_to_mem_valid, 0);
    chk("rst_allowin", ex_allowin, 1);
    chk("rst_en", data_sram_en, 0);
    chk("rst_we", data_sram_we, 0);
    chk("rst_busy", div_busy, 0);
    chk("rst_zip", ex_rf_zip[38:37], 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    tv.push_back(v(ADD,  32'd3,        32'd5,        32'h8));
    tv.push_back(v(SUB,  32'd3,        32'd5,        32'hFFFFFFFE));
    tv.push_back(v(SLT,  32'hFFFFFFFF, 32'd1,        32'd1));
    tv.push_back(v(SLTU, 32'hFFFFFFFF, 32'd1,        32'd0));
    tv.push_back(v(SLTU, 32'd1,        32'hFFFFFFFF, 32'd1));
    tv.push_back(v(AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000));
    tv.push_back(v(NOR,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F));
    tv.push_back(v(OR,   32'h12340000, 32'h00005678, 32'h12345678));
    tv.push_back(v(XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F));
    tv.push_back(v(SLL,  32'd1,        32'h24,       32'h10));
    tv.push_back(v(SRL,  32'h80000000, 32'd31,       32'd1));
    tv.push_back(v(SRA,  32'h80000000, 32'd4,        32'hF8000000));
    tv.push_back(v(LUI,  32'h11111111, 32'hABCDE000, 32'hABCDE000));
    tv.push_back(v(16'h0, 32'd5,       32'd6,        32'd0));
    tv.push_back(v(DIV,  -32'sd7,      32'd2,        32'hFFFFFFFD));
    tv.push_back(v(MOD,  -32'sd7,      32'd2,        32'hFFFFFFFF));
    tv.push_back(v(DIV,  32'd7,        -32'sd2,      32'hFFFFFFFD));
    tv.push_back(v(MOD,  32'd7,        -32'sd2,      32'd1));
    tv.push_back(v(DIVU, 32'd10,       32'd0,        32'hFFFFFFFF));
    tv.push_back(v(MODU, 32'd10,       32'd0,        32'hA));
    tv.push_back(v(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000));
    tv.push_back(v(MOD,  32'h80000000, 32'hFFFFFFFF, 32'd0));
    tv.push_back(v(DIVU, 32'd100,      32'd7,        32'd14));
    tv.push_back(v(MODU, 32'd100,      32'd7,        32'd2));
    tv.push_back(v(MODU, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE));
    tv.push_back(v(DIV,  -32'sd8,      32'd0,        32'd1));
    tv.push_back(v(MOD,  -32'sd8,      32'd0,        32'hFFFFFFF8));
    tv.push_back(v(ADD,  32'hFFFFFFFF, 32'd1,        32'd0));

    sb_on = 1'b1;
    foreach (tv[i]) begin
      wa = 5'(i);
      pc = 32'h1C000000 + 32'(i * 4);
      send(mk(tv[i].op, tv[i].a, tv[i].b, 32'd0, 1'b0, 1'b0, 1'b1, wa, pc),
           {1'b1, wa, pc, tv[i].exp, 1'b0}, 1'b1);
    end
    id_to_ex_valid = 1'b0;
    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(posedge clk);
    #1;
    chk("sb_drain", 71'(sbq.size()), 0);
    sb_on = 1'b0;

    // back-to-back add/sub with no bubble
    id_to_ex_wire  = mk(ADD, 32'd3, 32'd5, 32'd0, 0, 0, 1, 5'd1, 32'h100);
    id_to_ex_valid = 1'b1;
    @(posedge clk);
    #1 id_to_ex_wire = mk(SUB, 32'd3, 32'd5, 32'd0, 0, 0, 1, 5'd2, 32'h104);
    @(negedge clk);
    chk("b2b_v0", ex_to_mem_valid, 1);
    chk("b2b_r0", ex_to_mem_wire[32:1], 32'h8);
    @(posedge clk);
    #1 id_to_ex_valid = 1'b0;
    @(negedge clk);
    chk("b2b_v1", ex_to_mem_valid, 1);
    chk("b2b_r1", ex_to_mem_wire[32:1], 32'hFFFFFFFE);
    @(posedge clk);
    #1;

    // div.w latency, busy length and allowin
    send(mk(DIV, -32'sd7, 32'd2, 32'd0, 0, 0, 1, 5'd3, 32'h200), '0, 0);
    id_to_ex_valid = 1'b0;
    first = -1; busy = 0; alb = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (div_busy) busy++;
      if (ex_to_mem_valid) begin
        first = k;
        break;
      end
      if (ex_allowin) alb++;
    end
    chk("div_latency", 71'(first), 71'd33);
    chk("div_busy_cycles", 71'(busy), 71'd32);
    chk("div_allowin_low", 71'(alb), 71'd0);
    chk("div_result", ex_to_mem_wire[32:1], 32'hFFFFFFFD);
    @(posedge clk);
    #1;

    // store held under MEM stall, then a single request
    mem_allowin = 1'b0;
    send(mk(ADD, 32'h1000, 32'd4, 32'hDEADBEEF, 1, 0, 0, 5'd0, 32'h300),
         '0, 0);
    id_to_ex_valid = 1'b0;
    ens = 0;
    repeat (3) begin
      @(negedge clk);
      if (data_sram_en) ens++;
      chk("stall_we", data_sram_we, 4'hF);
      chk("stall_allowin", ex_allowin, 0);
    end
    chk("stall_en_cnt", 71'(ens), 71'd0);
    @(posedge clk);
    #1 mem_allowin = 1'b1;
    @(negedge clk);
    chk("st_en", data_sram_en, 1);
    chk("st_we", data_sram_we, 4'hF);
    chk("st_addr", data_sram_addr, 32'h1004);
    chk("st_wdata", data_sram_wdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("st_en_after", data_sram_en, 0);

    // load held in EX: forwarding flags
    @(posedge clk);
    #1 mem_allowin = 1'b0;
    send(mk(ADD, 32'h2000, 32'd8, 32'd0, 0, 1, 1, 5'd7, 32'h400), '0, 0);
    id_to_ex_valid = 1'b0;
    @(negedge clk);
    chk("ld_zip38", ex_rf_zip[38], 1);
    chk("ld_zip37", ex_rf_zip[37], 1);
    chk("ld_zip_wa", ex_rf_zip[36:32], 5'd7);
    chk("ld_zip_res", ex_rf_zip[31:0], 32'h2008);
    chk("ld_en_stall", data_sram_en, 0);
    @(posedge clk);
    #1 mem_allowin = 1'b1;
    @(negedge clk);
    chk("ld_en", data_sram_en, 1);
    chk("ld_we", data_sram_we, 4'h0);
    @(posedge clk);
    #1;

    // divide held in DONE while MEM stalls
    mem_allowin = 1'b0;
    send(mk(DIVU, 32'd100, 32'd7, 32'd0, 0, 0, 1, 5'd9, 32'h500), '0, 0);
    id_to_ex_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ex_to_mem_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    repeat (5) begin
      @(negedge clk);
      chk("done_valid", ex_to_mem_valid, 1);
      chk("done_busy", div_busy, 0);
      chk("done_res", ex_to_mem_wire[32:1], 32'd14);
      chk("done_zip", ex_rf_zip[31:0], 32'd14);
    end
    @(posedge clk);
    #1 mem_allowin = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_handoff", ex_to_mem_valid, 0);
    chk("done_allowin", ex_allowin, 1);

    // asynchronous reset with a store in flight
    send(mk(ADD, 32'h40, 32'd0, 32'h1, 1, 0, 0, 5'd0, 32'h600), '0, 0);
    id_to_ex_valid = 1'b0;
    @(negedge clk);
    chk("rs_en_pre", data_sram_en, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rs_valid", ex_to_mem_valid, 0);
    chk("rs_en", data_sram_en, 0);
    chk("rs_allowin", ex_allowin, 1);
    @(negedge clk);
    resetn = 1'b1;

    // reset during BUSY aborts the divide
    @(posedge clk);
    #1;
    send(mk(DIV, 32'd50, 32'd5, 32'd0, 0, 0, 1, 5'd4, 32'h700), '0, 0);
    id_to_ex_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rb_busy_pre", div_busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rb_busy", div_busy, 0);
    chk("rb_valid", ex_to_mem_valid, 0);
    chk("rb_allowin", ex_allowin, 1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    send(mk(ADD, 32'd7, 32'd9, 32'd0, 0, 0, 1, 5'd5, 32'h800), '0, 0);
    id_to_ex_valid = 1'b0;
    @(negedge clk);
    chk("rb_after_v", ex_to_mem_valid, 1);
    chk("rb_after_r", ex_to_mem_wire[32:1], 32'h10);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage in-order pipeline. It sits between the decode stage and the memory-access stage, and issues the data-SRAM request one cycle before MEM samples the read data. It contains:
- the single-cycle ALU;
- a 32-iteration radix-2 divider for div.w/mod.w/div.wu/mod.wu;
- the EX forwarding bundle.
It holds a divide instruction until its result is ready and then hands it to MEM through the valid/allowin handshake.

Parameters:
- ID_TO_EX_WIDTH, 152, width of the packed decode-to-execute bus.
- EX_TO_MEM_WIDTH, 71, width of the packed execute-to-memory bus.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ex_allowin  out  1  EX can accept a new instruction this cycle.
- id_to_ex_valid  in  1  decode presents a valid instruction.
- id_to_ex_wire  in  152  {alu_op[15:0], alu_src1[31:0], alu_src2[31:0], rkd_value[31:0], mem_we, res_from_mem, rf_we, rf_waddr[4:0], pc[31:0]}, MSB first.
- mem_allowin  in  1  MEM can accept.
- ex_to_mem_valid  out  1  EX instruction is complete and valid.
- ex_to_mem_wire  out  71  {rf_we, rf_waddr[4:0], pc[31:0], ex_result[31:0], res_from_mem}, MSB first.
- data_sram_en  out  1  data SRAM request enable.
- data_sram_we  out  4  byte write enables.
- data_sram_addr  out  32  byte address.
- data_sram_wdata  out  32  store data.
- ex_rf_zip  out  39  {ex_valid&res_from_mem, ex_valid&rf_we, rf_waddr[4:0], ex_result[31:0]}.
- div_busy  out  1  divider is in the BUSY state.

Behaviour:
- **Clock and reset.** One clock. Reset is asynchronous and active-low. Reset clears ex_valid, places the divider FSM in IDLE, and clears the iteration counter. The payload register is not reset.
- **Outputs in reset:**
  - ex_to_mem_valid=0, ex_allowin=1.
  - data_sram_en=0, data_sram_we=0, div_busy=0.
  - ex_rf_zip[38:37]=0.
- **Handshake:**
  - ex_allowin = ~ex_valid | (ex_ready_go & mem_allowin).
  - ex_to_mem_valid = ex_valid & ex_ready_go.
  - When ex_allowin=1, ex_valid takes id_to_ex_valid.
  - The payload register loads id_to_ex_wire when id_to_ex_valid & ex_allowin.
- **alu_op** is one-hot or all-zero:
  - bits 0..11 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - bits 12..15 = div (signed quotient), mod (signed remainder), divu, modu.
- **ALU ops:**
  - Shift amount is alu_src2[4:0].
  - lui result is alu_src2.
  - All-zero alu_op gives result 0.
  - ex_ready_go=1 the same cycle.
- **Divider FSM, states IDLE, BUSY, DONE:**
  - IDLE -> BUSY when ex_valid & a div bit is set. Entering BUSY latches |src1| and |src2| (or raw values for the unsigned ops) and the result signs, and clears the counter to 0.
  - BUSY: one restoring step per cycle, counter increments. At counter==31 the next state is DONE.
  - DONE: ex_ready_go=1 and the result is held. DONE -> IDLE when mem_allowin (handoff). Otherwise DONE persists and the divider is not restarted.
  - ex_ready_go=0 in IDLE and BUSY for a div instruction.
  - Minimum residency is 34 cycles: 1 IDLE cycle, 32 BUSY cycles, 1 DONE cycle.
- **Divider results:**
  - Signed sign fix: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient=0xFFFFFFFF (unsigned) or the sign-fixed value of all-ones magnitude; remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- **div_busy** = (state==BUSY).
- **Memory request:**
  - data_sram_en = ex_valid & ex_ready_go & mem_allowin & (mem_we | res_from_mem).
  - data_sram_we = {4{mem_we & ex_valid}}.
  - data_sram_addr = ALU add result.
  - data_sram_wdata = rkd_value.
  - The SRAM returns read data the cycle after en, aligned with MEM.
- **Forwarding:** ex_rf_zip always reflects the current ex_result, including the divider's held value. Bit 38 lets decode stall load-use hazards.
- **Simultaneous events:**
  - Handoff and a new load in the same cycle is legal. The new instruction sees the FSM in IDLE.
  - Reset asserted mid-BUSY aborts the divide and drops the instruction.
- **MEM stall:** if mem_allowin=0, ex_valid, the payload, the FSM and data_sram_en=0 are all held.

Test Plan:
- Reset mid-stream: resetn=0 asynchronously mid-cycle -> ex_to_mem_valid=0, data_sram_en=0 and ex_allowin=1 immediately, before the next edge.
- Back-to-back adds: add 3+5, then sub 3-5, with mem_allowin=1 -> ex_result 0x8, then 0xFFFFFFFE, on consecutive cycles with no bubble.
- div.w: -7/2 -> ex_to_mem_valid rises exactly 33 cycles after entry, ex_result 0xFFFFFFFD. mod.w gives 0xFFFFFFFF. div_busy high for 32 cycles. ex_allowin=0 throughout.
- Divide edge cases:
  - divu 10/0 -> 0xFFFFFFFF.
  - modu 10/0 -> 0xA.
  - div.w 0x80000000/0xFFFFFFFF -> 0x80000000.
- MEM stall: store addr 0x1000+4, data 0xDEADBEEF, with mem_allowin=0 for 3 cycles -> data_sram_en=0 while stalled. Then a single en=1 with we=0xF, addr 0x1004, wdata 0xDEADBEEF.
- Load forwarding: load held in EX -> ex_rf_zip[38]=1 and [37]=1. A divide held in DONE with mem_allowin=0 keeps its result stable and does not re-enter BUSY.
